// File: rtl/if_fetch_unit_pkg.sv
// Shared pipeline definitions for the instruction-fetch stage: opcode
// constants, width defaults and the HALT-drain state encoding.
package if_fetch_unit_pkg;

    localparam int PC_SIZE_DEF   = 32;
    localparam int INST_SIZE_DEF = 32;
    localparam int DRAIN_CNT_W   = 4;

    localparam logic [31:0] HALT_OPCODE = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;

    typedef enum logic [1:0] {
        FS_RUN    = 2'd0,
        FS_DRAIN  = 2'd1,
        FS_HALTED = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit_if_id_reg.sv
// IF/ID pipeline register: loads the fetched instruction and PC+4, holds on
// disable or stall, and collapses to a NOP bubble on flush.
module if_id_reg
    import if_fetch_unit_pkg::*;
#(
    parameter int PC_SIZE   = PC_SIZE_DEF,
    parameter int INST_SIZE = INST_SIZE_DEF
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 en_i,
    input  logic                 stall_i,
    input  logic                 flush_i,
    input  logic [INST_SIZE-1:0] instr_i,
    input  logic [PC_SIZE-1:0]   pc4_i,
    output logic [INST_SIZE-1:0] instr_o,
    output logic [PC_SIZE-1:0]   pc4_o,
    output logic                 valid_o
);

    logic [INST_SIZE-1:0] instr_q;
    logic [PC_SIZE-1:0]   pc4_q;
    logic                 valid_q;

    // Register update: reset > hold (disabled/stalled) > flush-to-NOP > load.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            instr_q <= INST_SIZE'(NOP_INSTR);
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else if (en_i && !stall_i) begin
            if (flush_i) begin
                instr_q <= INST_SIZE'(NOP_INSTR);
                pc4_q   <= '0;
                valid_q <= 1'b0;
            end else begin
                instr_q <= instr_i;
                pc4_q   <= pc4_i;
                valid_q <= 1'b1;
            end
        end
    end

    assign instr_o = instr_q;
    assign pc4_o   = pc4_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, next-PC select (sequential / JR /
// J / branch) and the IF/ID register. The HALT-drain machine
// (RUN -> DRAIN -> HALTED) is built only when IF_HALT_DETECT_EN is defined;
// otherwise the HALT opcode is fetched like any other word.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int PC_SIZE      = PC_SIZE_DEF,
    parameter int INST_SIZE    = INST_SIZE_DEF,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic                 i_stall,
    input  logic [INST_SIZE-1:0] i_instr,
    input  logic                 i_jump_taken,
    input  logic [PC_SIZE-1:0]   i_jump_addr,
    input  logic                 i_branch_taken,
    input  logic [PC_SIZE-1:0]   i_branch_addr,
    input  logic                 i_jr_taken,
    input  logic [PC_SIZE-1:0]   i_jr_addr,
    output logic [PC_SIZE-1:0]   o_pc,
    output logic [INST_SIZE-1:0] o_if_id_instr,
    output logic [PC_SIZE-1:0]   o_if_id_pc4,
    output logic                 o_if_id_valid,
    output logic                 o_halted
);

    if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 15) begin : g_bad_drain
        $error("DRAIN_CYCLES must be in 1..15");
    end

    logic [PC_SIZE-1:0] pc_q, pc_d;
    logic [PC_SIZE-1:0] pc_plus4;
    logic [PC_SIZE-1:0] target;
    logic               redirect;
    logic               advance;
    logic               ifid_en;
    logic               ifid_flush;

    assign advance  = i_enable & ~i_stall;
    assign pc_plus4 = pc_q + PC_SIZE'(4);

    // Redirect target select; at most one is expected, JR first for determinism.
    always_comb begin
        redirect = i_jr_taken | i_jump_taken | i_branch_taken;
        if (i_jr_taken)        target = i_jr_addr;
        else if (i_jump_taken) target = i_jump_addr;
        else                   target = i_branch_addr;
    end

`ifdef IF_HALT_DETECT_EN
    localparam logic [DRAIN_CNT_W-1:0] CNT_INIT = DRAIN_CNT_W'(DRAIN_CYCLES);

    fetch_state_e           state_q, state_d;
    logic [DRAIN_CNT_W-1:0] cnt_q, cnt_d;

    // Next PC / fetch state; the HALT word itself is latched into IF/ID while
    // the PC parks on it, then DRAIN feeds bubbles until the count expires.
    always_comb begin
        pc_d       = pc_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        ifid_flush = 1'b0;
        unique case (state_q)
            FS_RUN: begin
                if (redirect) begin
                    pc_d       = target;
                    ifid_flush = 1'b1;
                end else if (i_instr == INST_SIZE'(HALT_OPCODE)) begin
                    cnt_d   = CNT_INIT;
                    state_d = FS_DRAIN;
                end else begin
                    pc_d = pc_plus4;
                end
            end
            FS_DRAIN: begin
                ifid_flush = 1'b1;
                if (redirect) begin
                    // HALT sat in a branch shadow: abandon the drain.
                    pc_d    = target;
                    cnt_d   = '0;
                    state_d = FS_RUN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == 1) state_d = FS_HALTED;
                end
            end
            FS_HALTED: pc_d = pc_q;
            default:   state_d = FS_RUN;
        endcase
    end

    // PC and fetch-state registers advance only on enabled, unstalled edges.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            pc_q    <= '0;
            state_q <= FS_RUN;
            cnt_q   <= '0;
        end else if (advance) begin
            pc_q    <= pc_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ifid_en  = i_enable & (state_q != FS_HALTED);
    assign o_halted = (state_q == FS_HALTED);
`else
    // Next PC: redirect bubbles IF/ID, otherwise step sequentially.
    always_comb begin
        pc_d       = pc_plus4;
        ifid_flush = 1'b0;
        if (redirect) begin
            pc_d       = target;
            ifid_flush = 1'b1;
        end
    end

    // PC register advances only on enabled, unstalled edges.
    always_ff @(posedge i_clock) begin
        if (i_reset)      pc_q <= '0;
        else if (advance) pc_q <= pc_d;
    end

    assign ifid_en  = i_enable;
    assign o_halted = 1'b0;
`endif

    if_id_reg #(
        .PC_SIZE   (PC_SIZE),
        .INST_SIZE (INST_SIZE)
    ) u_if_id_reg (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .en_i    (ifid_en),
        .stall_i (i_stall),
        .flush_i (ifid_flush),
        .instr_i (i_instr),
        .pc4_i   (pc_plus4),
        .instr_o (o_if_id_instr),
        .pc4_o   (o_if_id_pc4),
        .valid_o (o_if_id_valid)
    );

    assign o_pc = pc_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: a vector table, hand-written HALT sequences and a
// randomized run, all checked against a behavioural fetch model.
module tb_if_fetch_unit;

    localparam int          DC   = 4;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst, en, st, jt, bt, jrt;
    logic [31:0] ja, ba, jra;
    logic [31:0] instr, pc, ifid_instr, ifid_pc4;
    logic        ifid_valid, halted;

    int total = 0;
    int bad   = 0;

    // Instruction memory contents, selectable per phase.
    logic        halt_on   = 1'b0;
    logic [31:0] halt_addr = 32'h0;
    logic        nop_mem   = 1'b1;

    always #5 clk = ~clk;

    always_comb
        instr = (halt_on && pc == halt_addr) ? HALT :
                (nop_mem ? 32'h0 : ({1'b0, pc[30:0]} ^ 32'h1234_5678));

    if_fetch_unit #(.PC_SIZE(32), .INST_SIZE(32), .DRAIN_CYCLES(DC)) dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_enable       (en),
        .i_stall        (st),
        .i_instr        (instr),
        .i_jump_taken   (jt),
        .i_jump_addr    (ja),
        .i_branch_taken (bt),
        .i_branch_addr  (ba),
        .i_jr_taken     (jrt),
        .i_jr_addr      (jra),
        .o_pc           (pc),
        .o_if_id_instr  (ifid_instr),
        .o_if_id_pc4    (ifid_pc4),
        .o_if_id_valid  (ifid_valid),
        .o_halted       (halted)
    );

    // ---------------- reference model ----------------
    logic [31:0] m_pc, m_ins, m_pc4;
    logic        m_valid;
    bit          m_draining, m_stopped;
    int          m_left;

    function automatic logic [31:0] imem(input logic [31:0] a);
        if (halt_on && a == halt_addr) return HALT;
        if (nop_mem) return 32'h0;
        return {1'b0, a[30:0]} ^ 32'h1234_5678;
    endfunction

    task automatic bubble();
        m_ins = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    endtask

    task automatic model_step();
        logic [31:0] word, tgt;
        bit          redir;
        if (rst) begin
            m_pc = 0; bubble(); m_draining = 0; m_stopped = 0; m_left = 0;
            return;
        end
        if (!en || st) return;
        redir = jrt || jt || bt;
        tgt   = jrt ? jra : (jt ? ja : ba);
        word  = imem(m_pc);
`ifdef IF_HALT_DETECT_EN
        if (m_stopped) return;
        if (redir) begin
            m_pc = tgt; bubble(); m_draining = 0; m_left = 0;
            return;
        end
        if (m_draining) begin
            bubble();
            m_left = m_left - 1;
            if (m_left == 0) begin m_draining = 0; m_stopped = 1; end
            return;
        end
        m_ins = word; m_pc4 = m_pc + 4; m_valid = 1'b1;
        if (word == HALT) begin m_draining = 1; m_left = DC; end
        else m_pc = m_pc + 4;
`else
        if (redir) begin m_pc = tgt; bubble(); return; end
        m_ins = word; m_pc4 = m_pc + 4; m_valid = 1'b1; m_pc = m_pc + 4;
`endif
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("model_pc",     pc,                   m_pc);
        chk("model_instr",  ifid_instr,           m_ins);
        chk("model_pc4",    ifid_pc4,             m_pc4);
        chk("model_valid",  {31'b0, ifid_valid},  {31'b0, m_valid});
        chk("model_halted", {31'b0, halted},      {31'b0, m_stopped});
    endtask

    task automatic drive(input logic r, input logic e, input logic s,
                         input logic j, input logic [31:0] jaddr,
                         input logic b, input logic [31:0] baddr,
                         input logic jr, input logic [31:0] jraddr);
        rst = r; en = e; st = s; jt = j; ja = jaddr; bt = b; ba = baddr; jrt = jr; jra = jraddr;
    endtask

    task automatic run();
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        rst, en, st, jt, bt, jrt;
        logic [31:0] ja, ba, jra;
        logic [31:0] e_pc, e_pc4;
        logic        e_v;
    } vec_t;

    vec_t tv[16];

    function automatic vec_t mk(input logic r, e, s, j, input logic [31:0] jaddr,
                                input logic b, input logic [31:0] baddr,
                                input logic jr, input logic [31:0] jraddr,
                                input logic [31:0] epc, epc4, input logic ev);
        vec_t v;
        v.rst = r; v.en = e; v.st = s; v.jt = j; v.ja = jaddr; v.bt = b; v.ba = baddr;
        v.jrt = jr; v.jra = jraddr; v.e_pc = epc; v.e_pc4 = epc4; v.e_v = ev;
        return v;
    endfunction

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        //        rst en st jt ja            bt ba        jr jra       pc            pc4        v
        tv[0]  = mk(1, 1, 0, 0, 0,            0, 0,        0, 0,        32'h0,        32'h0,     0);
        tv[1]  = mk(0, 1, 0, 0, 0,            0, 0,        0, 0,        32'h4,        32'h4,     1);
        tv[2]  = mk(0, 1, 0, 0, 0,            0, 0,        0, 0,        32'h8,        32'h8,     1);
        tv[3]  = mk(0, 1, 1, 0, 0,            0, 0,        0, 0,        32'h8,        32'h8,     1);
        tv[4]  = mk(0, 1, 1, 0, 0,            0, 0,        0, 0,        32'h8,        32'h8,     1);
        tv[5]  = mk(0, 1, 0, 0, 0,            0, 0,        0, 0,        32'hC,        32'hC,     1);
        tv[6]  = mk(0, 1, 0, 0, 0,            0, 0,        0, 0,        32'h10,       32'h10,    1);
        tv[7]  = mk(0, 1, 0, 1, 32'h100,      1, 32'h200,  0, 0,        32'h100,      32'h0,     0);
        tv[8]  = mk(0, 1, 0, 0, 0,            0, 0,        0, 0,        32'h104,      32'h104,   1);
        tv[9]  = mk(0, 0, 0, 1, 32'h500,      0, 0,        0, 0,        32'h104,      32'h104,   1);
        tv[10] = mk(0, 1, 1, 1, 32'h500,      0, 0,        0, 0,        32'h104,      32'h104,   1);
        tv[11] = mk(0, 1, 0, 1, 32'h500,      0, 0,        1, 32'h300,  32'h300,      32'h0,     0);
        tv[12] = mk(0, 1, 0, 1, 32'hFFFFFFFC, 0, 0,        0, 0,        32'hFFFFFFFC, 32'h0,     0);
        tv[13] = mk(0, 1, 0, 0, 0,            0, 0,        0, 0,        32'h0,        32'h0,     1);
        tv[14] = mk(0, 1, 0, 0, 0,            0, 0,        0, 0,        32'h4,        32'h4,     1);
        tv[15] = mk(1, 1, 0, 0, 0,            0, 0,        0, 0,        32'h0,        32'h0,     0);

        #2;
        nop_mem = 1'b1; halt_on = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive(tv[i].rst, tv[i].en, tv[i].st, tv[i].jt, tv[i].ja,
                  tv[i].bt, tv[i].ba, tv[i].jrt, tv[i].jra);
            step();
            chk($sformatf("tv%0d_pc", i),    pc,                  tv[i].e_pc);
            chk($sformatf("tv%0d_pc4", i),   ifid_pc4,            tv[i].e_pc4);
            chk($sformatf("tv%0d_valid", i), {31'b0, ifid_valid}, {31'b0, tv[i].e_v});
            chk($sformatf("tv%0d_halted", i), {31'b0, halted},    32'h0);
        end

        // HALT at PC 20, with a two-cycle stall inside the drain.
        halt_on = 1'b1; halt_addr = 32'd20;
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0); step();
        run();
        repeat (5) step();
        chk("halt_pre_pc", pc, 32'd20);
        step();
`ifdef IF_HALT_DETECT_EN
        chk("halt_edge_pc",    pc,         32'd20);
        chk("halt_edge_instr", ifid_instr, HALT);
        chk("halt_edge_pc4",   ifid_pc4,   32'd24);
        drive(0, 1, 1, 0, 0, 0, 0, 0, 0);
        repeat (2) begin step(); chk("halt_stall_halted", {31'b0, halted}, 32'h0); end
        run();
        for (int k = 1; k <= DC; k++) begin
            step();
            chk("drain_pc",     pc,                  32'd20);
            chk("drain_valid",  {31'b0, ifid_valid}, 32'h0);
            chk("drain_halted", {31'b0, halted},     (k == DC) ? 32'h1 : 32'h0);
        end
        drive(0, 1, 0, 1, 32'h80, 0, 0, 0, 0);
        repeat (3) begin
            step();
            chk("halted_hold_pc",  pc,               32'd20);
            chk("halted_hold_flg", {31'b0, halted},  32'h1);
        end
`else
        chk("halt_nofeat_pc",    pc,         32'd24);
        chk("halt_nofeat_instr", ifid_instr, HALT);
        step();
        chk("halt_nofeat_pc2",   pc,         32'd28);
`endif
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0); step();
        chk("halt_reset_pc",     pc,              32'h0);
        chk("halt_reset_halted", {31'b0, halted}, 32'h0);

        // HALT in a branch shadow: redirect during the drain returns to RUN.
        run();
        repeat (6) step();
        step();
        drive(0, 1, 0, 0, 0, 1, 32'h40, 0, 0); step();
        chk("shadow_pc",    pc,                  32'h40);
        chk("shadow_valid", {31'b0, ifid_valid}, 32'h0);
        run();
        for (int k = 0; k < 8; k++) begin
            step();
            chk("shadow_halted", {31'b0, halted}, 32'h0);
        end

        // Randomized run against the model.
        nop_mem = 1'b0; halt_on = 1'b1; halt_addr = 32'h30;
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0); step();
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] t0, t1, t2;
            t0 = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            t1 = ($urandom_range(0, 9) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15)))
                                             : {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            t2 = {24'h0, 8'($urandom_range(0, 255))};
            rst = ($urandom_range(0, 63) == 0);
            en  = ($urandom_range(0, 7) != 0);
            st  = ($urandom_range(0, 5) == 0);
            jt  = ($urandom_range(0, 15) == 0);
            bt  = ($urandom_range(0, 15) == 0);
            jrt = ($urandom_range(0, 23) == 0);
            ja = t0; ba = t1; jra = t2;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
